// File: rtl/aes_pkg.sv
// aes_pkg: shared types and constants for the AES job controller.
// State encoding, 128<->4x32 word split, default watchdog limit.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int WORD_W      = 32;
  localparam int TIMEOUT_DEF = 64;

  // Word i of a 128-bit block; word0 is the most significant.
  function automatic logic [31:0] word_of(
    input logic [127:0] v,
    input int           i
  );
    return v[127 - WORD_W*i -: WORD_W];
  endfunction

endpackage

// File: rtl/aes_rr_arb.sv
// aes_rr_arb: 2-way round-robin arbiter, purely combinational.
// On a tie the requester that was not served last wins.
module aes_rr_arb (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // One-hot grant from request pair and last-served bit
  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/aes_job_ctrl.sv
// aes_job_ctrl: shares one AES-128 core between two requesters.
// Round-robin grant, start pulse, watchdog-guarded completion.
module aes_job_ctrl
  import aes_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [127:0] req0_pt,
  input  logic [127:0] req1_pt,
  input  logic [127:0] req0_key,
  input  logic [127:0] req1_key,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_id,
  output logic         rsp_err,
  output logic         aes_start_out,
  output logic [31:0]  aes_pt0_out,
  output logic [31:0]  aes_pt1_out,
  output logic [31:0]  aes_pt2_out,
  output logic [31:0]  aes_pt3_out,
  output logic [31:0]  aes_key0_out,
  output logic [31:0]  aes_key1_out,
  output logic [31:0]  aes_key2_out,
  output logic [31:0]  aes_key3_out,
  input  logic [31:0]  aes_ct0_in,
  input  logic [31:0]  aes_ct1_in,
  input  logic [31:0]  aes_ct2_in,
  input  logic [31:0]  aes_ct3_in,
  input  logic         aes_valid_in,
  output logic         busy_out,
  output logic [15:0]  jobs_done_out
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST =
    TW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  state_t        nxt;
  logic [127:0]  pt_q;
  logic [127:0]  key_q;
  logic [127:0]  rsp_q;
  logic          id_q;
  logic          err_q;
  logic          last_q;
  logic [TW-1:0] timer;
  logic [15:0]   jobs_q;
  logic [1:0]    gnt;
  logic          hs0;
  logic          hs1;
  logic          take;
  logic          done_ok;
  logic          done_to;
  logic          rsp_hs;

  aes_rr_arb u_arb (
    .req  ({req1_valid, req0_valid}),
    .last (last_q),
    .gnt  (gnt)
  );

  // Ready is gated by reset so nothing is offered while held in reset.
  assign req0_ready = RST & (state == IDLE) & gnt[0];
  assign req1_ready = RST & (state == IDLE) & gnt[1];

  assign hs0  = req0_valid & req0_ready;
  assign hs1  = req1_valid & req1_ready;
  assign take = hs0 | hs1;

  // A core valid at timer 0 is a stale flag from the previous job.
  assign done_ok = (state == WAIT) & aes_valid_in
                 & (timer != '0);
  assign done_to = (state == WAIT) & (timer == T_LAST);
  assign rsp_hs  = (state == RESP) & rsp_ready;

  // Next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (take) nxt = LAUNCH;
      LAUNCH:  nxt = WAIT;
      WAIT:    if (done_ok | done_to) nxt = RESP;
      RESP:    if (rsp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= nxt;
  end

  // Holding registers for the granted job
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pt_q  <= '0;
      key_q <= '0;
      id_q  <= 1'b0;
    end else if (take) begin
      pt_q  <= hs1 ? req1_pt  : req0_pt;
      key_q <= hs1 ? req1_key : req0_key;
      id_q  <= hs1;
    end
  end

  // Watchdog timer, cleared at launch, counting only inside WAIT
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      timer <= '0;
    end else if (state == LAUNCH) begin
      timer <= '0;
    end else if (state == WAIT && nxt == WAIT) begin
      timer <= timer + 1'b1;
    end
  end

  // Response capture; a real completion beats a same-cycle timeout
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rsp_q <= '0;
      err_q <= 1'b0;
    end else if (done_ok) begin
      rsp_q <= {aes_ct0_in, aes_ct1_in,
                aes_ct2_in, aes_ct3_in};
      err_q <= 1'b0;
    end else if (done_to) begin
      rsp_q <= '0;
      err_q <= 1'b1;
    end
  end

  // Completion counter and round-robin history
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      jobs_q <= '0;
      last_q <= 1'b1;
    end else if (rsp_hs) begin
      jobs_q <= jobs_q + 16'd1;
      last_q <= id_q;
    end
  end

  assign rsp_valid     = (state == RESP);
  assign rsp_data      = rsp_q;
  assign rsp_id        = id_q;
  assign rsp_err       = err_q;
  assign aes_start_out = (state == LAUNCH);
  assign busy_out      = (state != IDLE);
  assign jobs_done_out = jobs_q;

  assign aes_pt0_out  = word_of(pt_q, 0);
  assign aes_pt1_out  = word_of(pt_q, 1);
  assign aes_pt2_out  = word_of(pt_q, 2);
  assign aes_pt3_out  = word_of(pt_q, 3);
  assign aes_key0_out = word_of(key_q, 0);
  assign aes_key1_out = word_of(key_q, 1);
  assign aes_key2_out = word_of(key_q, 2);
  assign aes_key3_out = word_of(key_q, 3);

endmodule

// File: doc/aes_job_ctrl.md
# aes_job_ctrl

Job controller that shares the single AES-128 encryption top level between two requesters. It accepts 128-bit plaintext/key jobs over valid/ready handshakes and arbitrates round-robin. It drives the core's start pulse and word-split plaintext/key buses, holds them stable for the whole operation, and returns the ciphertext tagged with the requester ID. A watchdog converts a missing core completion into an error response.

## Interface
- TIMEOUT_CYCLES, 64, maximum WAIT cycles before error response; legal range 2..65536.
- CLK  input  1  clock, all logic on rising edge
- RST  input  1  reset, asynchronous, active-low
- req0_valid / req1_valid  input  1  job offered by requester 0 / 1
- req0_ready / req1_ready  output  1  job accepted this cycle
- req0_pt / req1_pt  input  128  plaintext, word0 = [127:96] … word3 = [31:0]
- req0_key / req1_key  input  128  key, same word order
- rsp_valid  output  1  response available
- rsp_ready  input  1  response consumer ready
- rsp_data  output  128  ciphertext, word0 = [127:96]
- rsp_id  output  1  requester that issued the job
- rsp_err  output  1  1 = watchdog timeout, rsp_data = 0
- aes_start_out  output  1  one-cycle start pulse to core start_in
- aes_pt0_out..aes_pt3_out  output  32 each  plaintext words to core
- aes_key0_out..aes_key3_out  output  32 each  key words to core
- aes_ct0_in..aes_ct3_in  input  32 each  ciphertext words from core
- aes_valid_in  input  1  core valid_out
- busy_out  output  1  high in every state except IDLE
- jobs_done_out  output  16  count of completed responses, wraps 0xFFFF→0

## Operation
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE: if any reqN_valid is high, the grant goes to one requester. Both valid → the requester not served last wins. Only the granted reqN_ready is high, driven combinationally in IDLE. A handshake (valid & ready) captures pt, key and id into holding registers → LAUNCH. No valid → stay.
- LAUNCH: aes_start_out = 1 for exactly this cycle; timer cleared to 0 → WAIT.
- WAIT: timer increments each cycle.
  - aes_valid_in = 1 with timer ≥ 1 → capture ct0..3 into rsp_data, rsp_err = 0 → RESP.
  - Otherwise, timer == TIMEOUT_CYCLES-1 → rsp_data = 0, rsp_err = 1 → RESP.
  - Valid and timeout in the same cycle → valid wins.
  - aes_valid_in at timer 0 is ignored as a stale flag from the previous job.
- RESP: rsp_valid = 1 with data/id/err stable until rsp_ready. On the handshake: jobs_done_out +1, last-served ← rsp_id → IDLE.
- aes_pt*/aes_key* outputs come directly from the holding registers. They change only on an IDLE handshake, so they are stable from LAUNCH through RESP.
- aes_valid_in outside WAIT is ignored.
- reqN_ready is 0 in every state except IDLE. Requests arriving while busy wait; there is no queue.
- Timer width is clog2(TIMEOUT_CYCLES) bits; it never wraps because the timeout fires first.

## Timing
- Reset (RST low, any state, any time): FSM → IDLE; holding registers, rsp_data, rsp_id, rsp_err, timer and jobs_done_out = 0; last-served = 1, so req0 wins the first tie.
- While in reset: all outputs 0 (reqN_ready, rsp_valid, aes_start_out, busy_out, buses, jobs_done_out).
- Reset mid-job drops the job silently; no response is generated.
- Cycle sequence from a request handshake in IDLE at cycle T:
  - T+1: LAUNCH, aes_start_out high.
  - T+2: first WAIT cycle, timer = 0.
  - Core valid seen at WAIT cycle with timer = k (k ≥ 1) → rsp_valid high from the next cycle.
  - Controller overhead is 3 cycles plus core latency.
- Timeout: rsp_valid rises at WAIT entry + TIMEOUT_CYCLES cycles.
- rsp_ready held high → RESP lasts 1 cycle. The next request is accepted at the earliest one cycle after the response handshake, back in IDLE.
- Job throughput: 1 job per (core latency + 4) cycles minimum.

## Structure
- Package aes_pkg:
  - state enum (IDLE/LAUNCH/WAIT/RESP, 2 bits);
  - word-slice constants for the 128↔4×32 split (word i = [127-32i -: 32]);
  - default TIMEOUT_CYCLES.
- One sub-module, aes_rr_arb: 2-way round-robin arbiter.
  - Inputs: req[1:0], last-served bit.
  - Output: one-hot grant.
  - Purely combinational; the last-served register lives in aes_job_ctrl.
- Top level instantiates aes_job_ctrl next to the AES top; aes_start_out connects to start_in.

## Test plan
- Single job, req0, FIPS-197 vector: pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f → rsp_data 69c4e0d86a7b0430d8cdb78070b4c55a, rsp_id 0, rsp_err 0, one start pulse, jobs_done_out = 1.
- Both requesters valid continuously with 4 jobs each → grants alternate 0,1,0,1…; responses carry the matching ids; aes_pt* stable through every WAIT.
- Core stub never asserts valid, TIMEOUT_CYCLES = 8 → rsp_valid exactly 8 cycles after WAIT entry, rsp_err 1, rsp_data 0; next job then completes normally.
- rsp_ready held low 10 cycles in RESP → rsp_valid/data/id stay constant; reqN_ready stays 0; jobs_done_out increments only on the handshake.
- RST pulsed low during WAIT → all outputs 0 immediately; no response after release; the next tie is granted to req0.
- jobs_done_out preloaded near wrap (force 0xFFFF) plus one job → reads 0x0000.
